mem_arbiter: RTL and testbench

//  Shares one single-port memory2-style memory between three requesters: the

---
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Three-way arbiter (loader, data, fetch) in front of a single-port memory.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP and ends with a one-cycle ack.
module mem_arbiter #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic [DW-1:0] f_rdata,
  output logic          f_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    owner
);

  localparam int unsigned LCW = 4;
  localparam int unsigned SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_LD   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_F    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [LCW-1:0]  lat_cnt_q, lat_cnt_d;
  logic [SCW-1:0]  starve_q, starve_d;
  logic            acc_we_q, acc_we_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic [DW-1:0]   f_rdata_q, f_rdata_d;
  logic            ld_ack_q, ld_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            f_ack_q, f_ack_d;
  logic            busy_q, busy_d;

  logic            starve_sat;
  logic            fetch_forced;
  logic            any_req;

  assign starve_sat   = (starve_q == SCW'(STARVE_MAX));
  assign fetch_forced = f_req && starve_sat;
  assign any_req      = ld_req || d_req || f_req;

  // Grant selection, access sequencing and output staging
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    starve_d    = starve_q;
    acc_we_d    = acc_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    d_rdata_d   = d_rdata_q;
    f_rdata_d   = f_rdata_q;
    ld_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    f_ack_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!f_req) begin
          starve_d = '0;
        end
        if (ld_req) begin
          owner_d     = OWN_LD;
          acc_we_d    = 1'b1;
          mem_addr_d  = ld_addr;
          mem_wdata_d = ld_wdata;
        end else if (d_req && !fetch_forced) begin
          owner_d     = OWN_D;
          acc_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (f_req && !starve_sat) begin
            starve_d = starve_q + SCW'(1);
          end
        end else if (f_req) begin
          owner_d     = OWN_F;
          acc_we_d    = 1'b0;
          mem_addr_d  = f_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
        if (any_req) begin
          state_d  = S_ISSUE;
          mem_en_d = 1'b1;
          mem_we_d = acc_we_d;
        end
      end

      S_ISSUE: begin
        lat_cnt_d = LCW'(MEM_LAT);
        state_d   = S_WAIT;
      end

      // Final wait cycle: memory data is valid now, capture it for reads
      S_WAIT: begin
        if (lat_cnt_q <= LCW'(1)) begin
          state_d = S_RESP;
          if (!acc_we_q && owner_q == OWN_D) begin
            d_rdata_d = mem_rdata;
          end
          if (!acc_we_q && owner_q == OWN_F) begin
            f_rdata_d = mem_rdata;
          end
          ld_ack_d = (owner_q == OWN_LD);
          d_ack_d  = (owner_q == OWN_D);
          f_ack_d  = (owner_q == OWN_F);
        end else begin
          lat_cnt_d = lat_cnt_q - LCW'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end

      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      acc_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      d_rdata_q   <= '0;
      f_rdata_q   <= '0;
      ld_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      f_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      starve_q    <= starve_d;
      acc_we_q    <= acc_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      d_rdata_q   <= d_rdata_d;
      f_rdata_q   <= f_rdata_d;
      ld_ack_q    <= ld_ack_d;
      d_ack_q     <= d_ack_d;
      f_ack_q     <= f_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign ld_ack    = ld_ack_q;
  assign d_ack     = d_ack_q;
  assign f_ack     = f_ack_q;
  assign d_rdata   = d_rdata_q;
  assign f_rdata   = f_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each backed by a small behavioural memory with matching read latency.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  // Instance with MEM_LAT=1
  logic        ld_req, ld_ack, d_req, d_we, d_ack, f_req, f_ack;
  logic        mem_en, mem_we, busy;
  logic [1:0]  owner;
  logic [31:0] ld_addr, ld_wdata, d_addr, d_wdata, d_rdata, f_addr, f_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Instance with MEM_LAT=3
  logic        m3_ld_req, m3_ld_ack, m3_d_req, m3_d_we, m3_d_ack, m3_f_req, m3_f_ack;
  logic        m3_mem_en, m3_mem_we, m3_busy;
  logic [1:0]  m3_owner;
  logic [31:0] m3_ld_addr, m3_ld_wdata, m3_d_addr, m3_d_wdata, m3_d_rdata, m3_f_addr, m3_f_rdata;
  logic [31:0] m3_mem_addr, m3_mem_wdata, m3_mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter #(.DW(32), .AW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .Reset(Reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.DW(32), .AW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .Reset(Reset),
    .ld_req(m3_ld_req), .ld_addr(m3_ld_addr), .ld_wdata(m3_ld_wdata), .ld_ack(m3_ld_ack),
    .d_req(m3_d_req), .d_we(m3_d_we), .d_addr(m3_d_addr), .d_wdata(m3_d_wdata),
    .d_rdata(m3_d_rdata), .d_ack(m3_d_ack),
    .f_req(m3_f_req), .f_addr(m3_f_addr), .f_rdata(m3_f_rdata), .f_ack(m3_f_ack),
    .mem_en(m3_mem_en), .mem_we(m3_mem_we), .mem_addr(m3_mem_addr), .mem_wdata(m3_mem_wdata),
    .mem_rdata(m3_mem_rdata), .busy(m3_busy), .owner(m3_owner)
  );

  // Behavioural memories: read data appears MEM_LAT cycles after the mem_en cycle
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] rd1;
  logic [31:0] rd3_p0, rd3_p1, rd3_p2;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem1[mem_addr[7:2]] <= mem_wdata;
      rd1 <= mem1[mem_addr[7:2]];
    end else begin
      rd1 <= '0;
    end
  end
  assign mem_rdata = rd1;

  always @(posedge clk) begin
    if (m3_mem_en) begin
      if (m3_mem_we) mem3[m3_mem_addr[7:2]] <= m3_mem_wdata;
      rd3_p0 <= mem3[m3_mem_addr[7:2]];
    end else begin
      rd3_p0 <= '0;
    end
    rd3_p1 <= rd3_p0;
    rd3_p2 <= rd3_p1;
  end
  assign m3_mem_rdata = rd3_p2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (!mem_en && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_en_seen"}, 64'(mem_en), 64'(1));
  endtask

  // One access on the LAT=1 instance: issue fields, then ack two cycles later
  task automatic do_access(input string tag, input logic [1:0] own, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    logic [2:0] exp_ack;
    case (own)
      2'd1:    exp_ack = 3'b100;
      2'd2:    exp_ack = 3'b010;
      default: exp_ack = 3'b001;
    endcase
    wait_en(tag);
    chk({tag, "_owner"}, 64'(owner), 64'(own));
    chk({tag, "_we"}, 64'(mem_we), 64'(we));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(addr));
    if (we) chk({tag, "_wdata"}, 64'(mem_wdata), 64'(wdata));
    tick();
    chk({tag, "_wait"}, 64'({mem_en, ld_ack, d_ack, f_ack}), 64'(0));
    tick();
    chk({tag, "_ack"}, 64'({ld_ack, d_ack, f_ack}), 64'(exp_ack));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    mem1[4]  = 32'h8C010004;
    mem1[5]  = 32'h00000013;
    mem3[16] = 32'h00001234;

    Reset = 1'b0;
    {ld_req, d_req, d_we, f_req} = '0;
    {ld_addr, ld_wdata, d_addr, d_wdata, f_addr} = '0;
    {m3_ld_req, m3_d_req, m3_d_we, m3_f_req} = '0;
    {m3_ld_addr, m3_ld_wdata, m3_d_addr, m3_d_wdata, m3_f_addr} = '0;

    // Reset state
    tick();
    tick();
    chk("rst_outs", 64'({mem_en, mem_we, busy, owner, ld_ack, d_ack, f_ack}), 64'(0));
    chk("rst_rdata", {d_rdata, f_rdata}, 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));

    // 1: single fetch after reset release
    f_req = 1'b1; f_addr = 32'h10;
    tick();
    Reset = 1'b1;
    tick();
    chk("t1_en_T", 64'(mem_en), 64'(1));
    chk("t1_busy_T", 64'(busy), 64'(1));
    do_access("t1", 2'd3, 1'b0, 32'h10, 32'h0);
    chk("t1_f_rdata", 64'(f_rdata), 64'h8C010004);
    chk("t1_busy_ack", 64'(busy), 64'(1));
    f_req = 1'b0;
    tick();
    chk("t1_idle", 64'({busy, owner, f_ack}), 64'(0));
    chk("t1_f_rdata_held", 64'(f_rdata), 64'h8C010004);

    // 2: simultaneous data store and fetch; data first
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    f_req = 1'b1; f_addr = 32'h14;
    do_access("t2_d", 2'd2, 1'b1, 32'h20, 32'hDEADBEEF);
    chk("t2_d_rdata_kept", 64'(d_rdata), 64'(0));
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("t2_gap_en", 64'(mem_en), 64'(0));
    tick();
    chk("t2_f_next_en", 64'(mem_en), 64'(1));
    do_access("t2_f", 2'd3, 1'b0, 32'h14, 32'h0);
    chk("t2_f_rdata", 64'(f_rdata), 64'h13);
    f_req = 1'b0;
    tick();

    // 3: data held with fetch pending; fetch forced on the 5th grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    f_req = 1'b1; f_addr = 32'h10;
    begin
      logic [1:0] exp_own [0:5];
      exp_own = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
      for (int g = 0; g < 6; g++) begin
        wait_en($sformatf("t3_g%0d", g));
        chk($sformatf("t3_owner_g%0d", g), 64'(owner), 64'(exp_own[g]));
        if (g == 5) begin
          d_req = 1'b0;
          f_req = 1'b0;
        end
        tick();
      end
    end
    tick();
    chk("t3_last_ack", 64'({ld_ack, d_ack, f_ack}), 64'(3'b010));
    chk("t3_d_rdata", 64'(d_rdata), 64'hDEADBEEF);
    tick();
    tick();

    // 4: all three at once; order loader, data, fetch
    ld_req = 1'b1; ld_addr = 32'h30; ld_wdata = 32'hCAFEF00D;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    f_req = 1'b1; f_addr = 32'h10;
    do_access("t4_ld", 2'd1, 1'b1, 32'h30, 32'hCAFEF00D);
    ld_req = 1'b0;
    do_access("t4_d", 2'd2, 1'b0, 32'h30, 32'h0);
    chk("t4_d_rdata", 64'(d_rdata), 64'hCAFEF00D);
    d_req = 1'b0;
    do_access("t4_f", 2'd3, 1'b0, 32'h10, 32'h0);
    chk("t4_f_rdata", 64'(f_rdata), 64'h8C010004);
    f_req = 1'b0;
    tick();

    // 5: MEM_LAT=3 data read
    m3_d_req = 1'b1; m3_d_we = 1'b0; m3_d_addr = 32'h40;
    begin
      int n = 0;
      while (!m3_mem_en && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t5_en_seen", 64'(m3_mem_en), 64'(1));
    chk("t5_owner", 64'(m3_owner), 64'(2));
    tick();
    chk("t5_en_T1", 64'(m3_mem_en), 64'(0));
    tick();
    tick();
    chk("t5_ack_T3", 64'(m3_d_ack), 64'(0));
    tick();
    chk("t5_ack_T4", 64'(m3_d_ack), 64'(1));
    chk("t5_d_rdata", 64'(m3_d_rdata), 64'h1234);
    m3_d_req = 1'b0;
    tick();
    chk("t5_idle", 64'({m3_busy, m3_d_ack}), 64'(0));

    // 6: reset during WAIT abandons the access; request re-issued afterwards
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    wait_en("t6");
    tick();
    chk("t6_in_wait", 64'(busy), 64'(1));
    Reset = 1'b0;
    #1;
    chk("t6_rst_outs", 64'({mem_en, mem_we, busy, owner, ld_ack, d_ack, f_ack}), 64'(0));
    chk("t6_rst_rdata", {d_rdata, f_rdata}, 64'(0));
    tick();
    tick();
    chk("t6_no_ack", 64'({ld_ack, d_ack, f_ack, mem_en}), 64'(0));
    Reset = 1'b1;
    tick();
    chk("t6_reissue_en", 64'(mem_en), 64'(1));
    do_access("t6_re", 2'd2, 1'b0, 32'h20, 32'h0);
    chk("t6_d_rdata", 64'(d_rdata), 64'hDEADBEEF);
    d_req = 1'b0;
    tick();
    chk("t6_idle", 64'({busy, owner}), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
